// File: rtl/bound_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bound_counter: registered up/down counter between programmable     |
// | bounds with optional bounce and one-cycle bound-hit pulses.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bound_counter #(
  parameter int unsigned        WIDTH = 5,
  parameter logic [WIDTH-1:0]   INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             dir,
  input  logic             stop,
  input  logic             bounce_en,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             hit_hi,
  output logic             hit_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_hit_hi;
  logic             r_hit_lo;
  logic             w_hit_hi_nxt;
  logic             w_hit_lo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= INIT;
      r_hit_hi <= 1'b0;
      r_hit_lo <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_hit_hi <= w_hit_hi_nxt;
      r_hit_lo <= w_hit_lo_nxt;
    end
  end

  // Bound compares use >= / <= so a count loaded outside the window turns
  // instead of stepping further, which also rules out wrap-around.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_hit_hi_nxt = 1'b0;
    w_hit_lo_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = INIT;
    end else if (load_en) begin
      w_count_nxt = load_val;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = dir ? S_UP : S_DOWN;
          end
        end
        S_UP: begin
          if (r_count >= hi_bound) begin
            w_hit_hi_nxt = 1'b1;
            w_state_nxt  = bounce_en ? S_DOWN : S_IDLE;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
        S_DOWN: begin
          if (r_count <= lo_bound) begin
            w_hit_lo_nxt = 1'b1;
            w_state_nxt  = bounce_en ? S_UP : S_IDLE;
          end else begin
            w_count_nxt = r_count - 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign count  = r_count;
  assign state  = r_state;
  assign busy   = (r_state != S_IDLE);
  assign hit_hi = r_hit_hi;
  assign hit_lo = r_hit_lo;

endmodule
`default_nettype wire

// File: tb/tb_bound_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bound_counter: scoreboard bench with directed and random stimulus|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bound_counter;

  localparam int c_width = 5;
  localparam int c_init  = 0;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic               load_en;
  logic [c_width-1:0] load_val;
  logic               start;
  logic               dir;
  logic               stop;
  logic               bounce_en;
  logic [c_width-1:0] lo_bound;
  logic [c_width-1:0] hi_bound;
  logic [c_width-1:0] count;
  logic [1:0]         state;
  logic               busy;
  logic               hit_hi;
  logic               hit_lo;

  bound_counter #(.WIDTH(c_width), .INIT(c_init)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load_en(load_en),
    .load_val(load_val), .start(start), .dir(dir), .stop(stop),
    .bounce_en(bounce_en), .lo_bound(lo_bound), .hi_bound(hi_bound),
    .count(count), .state(state), .busy(busy),
    .hit_hi(hit_hi), .hit_lo(hit_lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int count;
    int state;
    int busy;
    int hh;
    int hl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: mode is the step direction (+1 up, -1 down, 0 idle).
  int m_count;
  int m_mode;
  int m_hh;
  int m_hl;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_count = c_init;
    m_mode  = 0;
    m_hh    = 0;
    m_hl    = 0;
  endfunction

  function automatic void model_step();
    m_hh = 0;
    m_hl = 0;
    if (clear) begin
      m_count = c_init;
      m_mode  = 0;
    end else if (load_en) begin
      m_count = int'(load_val);
    end else if (stop) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = dir ? 1 : -1;
    end else if (m_mode == 1) begin
      if (m_count >= int'(hi_bound)) begin
        m_hh   = 1;
        m_mode = bounce_en ? -1 : 0;
      end else begin
        m_count = m_count + 1;
      end
    end else begin
      if (m_count <= int'(lo_bound)) begin
        m_hl   = 1;
        m_mode = bounce_en ? 1 : 0;
      end else begin
        m_count = m_count - 1;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.count = m_count;
    e.state = (m_mode == 1) ? 1 : ((m_mode == -1) ? 2 : 0);
    e.busy  = (m_mode != 0) ? 1 : 0;
    e.hh    = m_hh;
    e.hl    = m_hl;
    return e;
  endfunction

  // Inputs are set at a falling edge; the expectation for the next rising
  // edge is queued before time advances.
  task automatic tick();
    model_step();
    q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic quiet();
    clear   = 1'b0;
    load_en = 1'b0;
    stop    = 1'b0;
    start   = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count",  int'(count),  e.count);
      chk("state",  int'(state),  e.state);
      chk("busy",   int'(busy),   e.busy);
      chk("hit_hi", int'(hit_hi), e.hh);
      chk("hit_lo", int'(hit_lo), e.hl);
      chk("hit_exclusive", int'(hit_hi & hit_lo), 0);
    end
  end

  initial begin
    int r;
    rst_n     = 1'b0;
    clear     = 1'b0;
    load_en   = 1'b0;
    load_val  = '0;
    start     = 1'b0;
    dir       = 1'b0;
    stop      = 1'b0;
    bounce_en = 1'b1;
    lo_bound  = '0;
    hi_bound  = 5'd10;
    model_reset();

    @(negedge clk);
    #1;
    chk("reset_count", int'(count), c_init);
    chk("reset_state", int'(state), 0);
    chk("reset_busy",  int'(busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while counting up at count 3
    start = 1'b1; dir = 1'b1;
    tick();
    quiet();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_busy",  int'(busy),  0);
    chk("async_rst_hits",  int'({hit_hi, hit_lo}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Full bounce cycle 0..5..0 and back up
    lo_bound = 5'd0; hi_bound = 5'd5; bounce_en = 1'b1;
    start = 1'b1; dir = 1'b1;
    tick();
    quiet();
    repeat (16) tick();

    // No wrap at the top with bounce disabled
    stop = 1'b1; tick(); quiet();
    bounce_en = 1'b0; lo_bound = 5'd2; hi_bound = 5'd31;
    load_en = 1'b1; load_val = 5'd31; tick(); quiet();
    start = 1'b1; dir = 1'b1; tick(); quiet();
    repeat (3) tick();

    // Load above the window while counting up
    bounce_en = 1'b1; lo_bound = 5'd0; hi_bound = 5'd10;
    clear = 1'b1; tick(); quiet();
    start = 1'b1; dir = 1'b1; tick(); quiet();
    repeat (4) tick();
    load_en = 1'b1; load_val = 5'd20; tick(); quiet();
    repeat (3) tick();

    // Priority: clear over load/start, stop over start
    clear = 1'b1; load_en = 1'b1; load_val = 5'd9; start = 1'b1; tick(); quiet();
    stop = 1'b1; start = 1'b1; dir = 1'b1; tick(); quiet();
    tick();

    // Inverted bounds: turn every cycle with count frozen
    lo_bound = 5'd7; hi_bound = 5'd3; bounce_en = 1'b1;
    load_en = 1'b1; load_val = 5'd5; tick(); quiet();
    start = 1'b1; dir = 1'b1; tick(); quiet();
    repeat (6) tick();

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      r         = $urandom_range(0, 99);
      clear     = (r < 2);
      load_en   = (r >= 2 && r < 6);
      stop      = (r >= 6 && r < 10);
      start     = ($urandom_range(0, 3) == 0);
      dir       = 1'($urandom);
      load_val  = 5'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        lo_bound  = 5'($urandom);
        hi_bound  = 5'($urandom);
        bounce_en = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    quiet();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bound_counter.md
Name: bound_counter

Overview:
- Parametrised registered bound counter for the flasher datapath; successor to the combinational next-counter logic.
- Holds the count register and an internal direction FSM (IDLE/UP/DOWN).
- Counts between programmable lower and upper bounds, optionally bouncing at each bound, and pulses a flag on every bound hit.
- Sits between the flasher control FSM (commands) and the LED output stage (consumes count/state).

Parameters:
WIDTH, 5, count and bound width in bits
INIT, 0, count value on reset and on clear (WIDTH bits)

Ports:
clk  in  1  clock; all registers rising-edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  sync clear: count=INIT, state=IDLE
load_en  in  1  sync load of load_val into count
load_val  in  WIDTH  load value
start  in  1  begin counting from IDLE; ignored when busy
dir  in  1  start direction, sampled with start: 1=UP, 0=DOWN
stop  in  1  return to IDLE, count held
bounce_en  in  1  1: reverse at bound; 0: go IDLE at bound
lo_bound  in  WIDTH  lower bound, unsigned
hi_bound  in  WIDTH  upper bound, unsigned
count  out  WIDTH  registered count
state  out  2  00 IDLE, 01 UP, 10 DOWN (11 unused)
busy  out  1  state != IDLE (combinational decode of state reg)
hit_hi  out  1  one-cycle pulse: upper bound reached in UP
hit_lo  out  1  one-cycle pulse: lower bound reached in DOWN

Behaviour:
- Reset (rst_n=0, async): count=INIT, state=IDLE, hit_hi=0, hit_lo=0, busy=0. Reset mid-count aborts immediately. After release, first action is at the next edge.
- Per-edge priority: clear > load_en > stop > start > counting.
- clear: count=INIT, state=IDLE, flags 0.
- load_en: count=load_val. State unchanged. No step and no bound check that cycle. Flags 0.
- stop (no clear/load): state=IDLE, count held, flags 0.
- IDLE:
  - start=1 moves to UP if dir=1, else DOWN. Count unchanged on the start edge.
  - Otherwise count is held.
- UP:
  - If count >= hi_bound: no step, hit_hi=1 next cycle, state becomes DOWN if bounce_en else IDLE.
  - Else count = count+1.
- DOWN:
  - If count <= lo_bound: no step, hit_lo=1 next cycle, state becomes UP if bounce_en else IDLE.
  - Else count = count-1.
- Arithmetic: WIDTH-bit unsigned. The >= / <= compares guarantee no wrap past 2^WIDTH-1 or below 0, even when count was loaded outside the bounds.
- Out-of-window start: start UP with count > hi_bound turns on the first counting cycle; likewise DOWN with count < lo_bound.
- lo_bound > hi_bound: legal but degenerate.
  - With bounce_en=1, each counting cycle is a turn: hit_hi and hit_lo alternate every cycle, count frozen.
  - With bounce_en=0, the first counting cycle goes IDLE.
- lo_bound == hi_bound == count: turns every cycle with bounce_en=1.
- Bounds and bounce_en are sampled every cycle; changes take effect at the next compare.
- hit_hi/hit_lo are registered, high exactly one cycle per turn, never both in the same cycle.
- start while busy is ignored.
- start together with stop: stop wins, state=IDLE.

Test Plan:
1. Reset during UP at count=3 -> count=0, state=IDLE, busy=0, flags 0 asynchronously, before the next edge.
2. WIDTH=5, lo=0, hi=5, bounce_en=1, start dir=1 from 0 -> count 1,2,3,4,5 on edges 2-6. Edge 7: hit_hi=1, state=DOWN, count 5. Then 4,3,2,1,0, then a hit_lo pulse, then UP.
3. bounce_en=0, lo=2, hi=31, load 31, start UP -> next counting edge: hit_hi=1, state=IDLE, count stays 31 (no wrap to 0).
4. UP at count=4: load_en=1, load_val=20, hi=10 -> count=20, state UP. Next edge: hit_hi=1, state=DOWN, count 20. Then count 19.
5. Same-cycle clear+load_en+start -> count=INIT, state=IDLE. Same-cycle stop+start in IDLE -> state stays IDLE.
6. lo=7, hi=3, bounce_en=1, start UP at count=5 -> hit_hi, hit_lo alternate every cycle, count fixed at 5, busy=1.
